// File: rtl/ppfifo_pattern_check_sink.sv
// ppfifo_pattern_check_sink
//
// Read-side sink for a ping-pong FIFO. Claims each ready block, drains it
// word by word (optionally throttled), and checks every consumed word against
// an incrementing pattern that starts at i_seed and keeps counting across
// blocks. Running statistics and the first failing word are exposed as
// registered outputs for DMA/loopback benches and hardware self-test.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   i_enable            allow new blocks to be claimed
//   i_check_en          enable pattern comparison (pattern advances regardless)
//   i_clear             one-cycle pulse: clear stats, reload pattern from i_seed
//   i_seed              first expected word after rst/i_clear
//   i_throttle          idle cycles inserted between read strobes
//   i_rd_rdy            ppfifo: a block is ready
//   o_rd_act            ppfifo: block claimed / being read
//   i_rd_size           ppfifo: words in the ready block (sampled at claim only)
//   o_rd_stb            ppfifo: consume current word
//   i_rd_data           ppfifo: current word, valid while o_rd_stb is high
//   o_word_count        words consumed since rst/i_clear (saturating)
//   o_block_count       blocks released since rst/i_clear (saturating)
//   o_error_count       mismatched words since rst/i_clear (saturating)
//   o_error             sticky mismatch flag
//   o_first_err_index   word count at which the first mismatch occurred
//   o_first_err_data    received data of the first mismatched word
//   o_busy              FSM is not idle

module ppfifo_pattern_check_sink #(
  parameter int DATA_WIDTH = 32,
  parameter int SIZE_WIDTH = 24,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_enable,
  input  logic                  i_check_en,
  input  logic                  i_clear,
  input  logic [DATA_WIDTH-1:0] i_seed,
  input  logic [7:0]            i_throttle,
  input  logic                  i_rd_rdy,
  output logic                  o_rd_act,
  input  logic [SIZE_WIDTH-1:0] i_rd_size,
  output logic                  o_rd_stb,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic [CNT_WIDTH-1:0]  o_word_count,
  output logic [CNT_WIDTH-1:0]  o_block_count,
  output logic [CNT_WIDTH-1:0]  o_error_count,
  output logic                  o_error,
  output logic [CNT_WIDTH-1:0]  o_first_err_index,
  output logic [DATA_WIDTH-1:0] o_first_err_data,
  output logic                  o_busy
);

  localparam logic [DATA_WIDTH-1:0] DATA_ONE = DATA_WIDTH'(1);
  localparam logic [SIZE_WIDTH-1:0] SIZE_ONE = SIZE_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Statistics counters stick at all-ones instead of wrapping, so a long
  // soak run never reports a misleadingly small count.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
    return (value == CNT_MAX) ? value : value + CNT_ONE;
  endfunction

  // ---------------------------------------------------------------------------
  // Read-side FSM
  // ---------------------------------------------------------------------------
  state_t                state;
  state_t                state_next;
  logic [SIZE_WIDTH-1:0] r_size;
  logic [SIZE_WIDTH-1:0] size_next;
  logic [SIZE_WIDTH-1:0] r_count;
  logic [SIZE_WIDTH-1:0] count_next;
  logic [7:0]            r_throttle;
  logic [7:0]            throttle_next;
  logic                  act_next;
  logic                  stb_next;
  logic                  block_done;

  // NOTE: every signal written here gets a default first; a path that left one
  // unassigned would make synthesis infer a latch.
  always_comb begin
    state_next    = state;
    size_next     = r_size;
    count_next    = r_count;
    throttle_next = r_throttle;
    act_next      = o_rd_act;
    stb_next      = 1'b0;
    block_done    = 1'b0;

    unique case (state)
      IDLE: begin
        if (i_enable && i_rd_rdy && !o_rd_act) begin
          // The block size is captured once; the ppfifo may change i_rd_size
          // while we are still draining this block.
          size_next     = i_rd_size;
          count_next    = '0;
          // Every block starts with its first strobe on the cycle after the
          // claim, independent of idle cycles left over from the last block.
          throttle_next = '0;
          act_next      = 1'b1;
          state_next    = READ;
        end
      end

      READ: begin
        if (r_count >= r_size) begin
          // Release does not wait out the throttle: act drops the cycle after
          // the final strobe (or right after the claim for an empty block).
          act_next   = 1'b0;
          block_done = 1'b1;
          state_next = RELEASE;
        end else if (r_throttle != 8'd0) begin
          throttle_next = r_throttle - 8'd1;
        end else begin
          stb_next      = 1'b1;
          count_next    = r_count + SIZE_ONE;
          // i_throttle is only looked at here, so a change applies from the
          // next strobe gap onwards.
          throttle_next = i_throttle;
        end
      end

      RELEASE: begin
        // One extra act-low cycle so the ppfifo sees at least a two-cycle gap.
        state_next = IDLE;
      end

      default: begin
        act_next   = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      r_size     <= '0;
      r_count    <= '0;
      r_throttle <= '0;
      o_rd_act   <= 1'b0;
      o_rd_stb   <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      state      <= state_next;
      r_size     <= size_next;
      r_count    <= count_next;
      r_throttle <= throttle_next;
      o_rd_act   <= act_next;
      o_rd_stb   <= stb_next;
      o_busy     <= (state_next != IDLE);
    end
  end

  // ---------------------------------------------------------------------------
  // Pattern checker and statistics
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_expected;
  logic                  word_hit;
  logic                  mismatch;

  // i_rd_data is valid during the cycle o_rd_stb is high, so the word is
  // checked at the edge that ends the strobe. A simultaneous i_clear wins
  // and the word is dropped from the statistics.
  assign word_hit = o_rd_stb && !i_clear;
  assign mismatch = word_hit && i_check_en && (i_rd_data != r_expected);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_expected        <= i_seed;
      o_word_count      <= '0;
      o_block_count     <= '0;
      o_error_count     <= '0;
      o_error           <= 1'b0;
      o_first_err_index <= '0;
      o_first_err_data  <= '0;
    end else if (i_clear) begin
      // A word consumed on the clear cycle uses up the seed value itself, so
      // the following word must match seed+1.
      r_expected        <= o_rd_stb ? i_seed + DATA_ONE : i_seed;
      o_word_count      <= '0;
      o_block_count     <= '0;
      o_error_count     <= '0;
      o_error           <= 1'b0;
      o_first_err_index <= '0;
      o_first_err_data  <= '0;
    end else begin
      if (block_done) begin
        o_block_count <= sat_inc(o_block_count);
      end

      if (word_hit) begin
        // The pattern advances whether or not checking is enabled, so checking
        // can be switched on mid-stream without losing alignment.
        r_expected   <= r_expected + DATA_ONE;
        o_word_count <= sat_inc(o_word_count);
      end

      if (mismatch) begin
        o_error_count <= sat_inc(o_error_count);
        o_error       <= 1'b1;
        if (!o_error) begin
          o_first_err_index <= o_word_count;
          o_first_err_data  <= i_rd_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_ppfifo_pattern_check_sink.sv
// Self-checking bench for ppfifo_pattern_check_sink.
// A small ppfifo source drives blocks; a behavioural scoreboard (expected
// pattern value plus counters updated per consumed word) and closed-form
// strobe/act timing give the expected results.

module tb_ppfifo_pattern_check_sink;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_enable;
  logic        i_check_en;
  logic        i_clear;
  logic [31:0] i_seed;
  logic [7:0]  i_throttle;
  logic        i_rd_rdy;
  logic        o_rd_act;
  logic [23:0] i_rd_size;
  logic        o_rd_stb;
  logic [31:0] i_rd_data;
  logic [31:0] o_word_count;
  logic [31:0] o_block_count;
  logic [31:0] o_error_count;
  logic        o_error;
  logic [31:0] o_first_err_index;
  logic [31:0] o_first_err_data;
  logic        o_busy;

  ppfifo_pattern_check_sink #(
    .DATA_WIDTH(32),
    .SIZE_WIDTH(24),
    .CNT_WIDTH (32)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .i_enable         (i_enable),
    .i_check_en       (i_check_en),
    .i_clear          (i_clear),
    .i_seed           (i_seed),
    .i_throttle       (i_throttle),
    .i_rd_rdy         (i_rd_rdy),
    .o_rd_act         (o_rd_act),
    .i_rd_size        (i_rd_size),
    .o_rd_stb         (o_rd_stb),
    .i_rd_data        (i_rd_data),
    .o_word_count     (o_word_count),
    .o_block_count    (o_block_count),
    .o_error_count    (o_error_count),
    .o_error          (o_error),
    .o_first_err_index(o_first_err_index),
    .o_first_err_data (o_first_err_data),
    .o_busy           (o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  // Per-block observations from the source driver.
  int          t_act;
  int          t_fall;
  bit          got_timeout;
  bit          busy_at_fall;
  int          stb_times[$];
  logic [31:0] src[$];

  // Scoreboard.
  logic [31:0] m_exp;
  logic [31:0] m_words;
  logic [31:0] m_blocks;
  logic [31:0] m_errs;
  logic        m_error;
  logic [31:0] m_idx;
  logic [31:0] m_data;

  typedef logic [160:0] stats_t;

  function automatic stats_t dut_vec();
    return {o_word_count, o_block_count, o_error_count, o_error, o_first_err_index, o_first_err_data};
  endfunction

  function automatic stats_t model_vec();
    return {m_words, m_blocks, m_errs, m_error, m_idx, m_data};
  endfunction

  function automatic string dut_str();
    return $sformatf("w=%0d b=%0d e=%0d err=%0b idx=%0d data=%h",
                     o_word_count, o_block_count, o_error_count, o_error, o_first_err_index, o_first_err_data);
  endfunction

  function automatic string model_str();
    return $sformatf("w=%0d b=%0d e=%0d err=%0b idx=%0d data=%h",
                     m_words, m_blocks, m_errs, m_error, m_idx, m_data);
  endfunction

  // Edge at which act must fall for a block claimed at t_act.
  function automatic int exp_fall(input int size, input int thr);
    return (size == 0) ? t_act + 1 : t_act + 1 + (size - 1) * (thr + 1) + 1;
  endfunction

  // Index of the first strobe not at t_act+1+i*(thr+1), or -1.
  function automatic int first_bad_stb(input int thr);
    foreach (stb_times[i]) begin
      if (stb_times[i] != t_act + 1 + i * (thr + 1)) return i;
    end
    return -1;
  endfunction

  task automatic model_reset(input logic [31:0] seed);
    m_exp    = seed;
    m_words  = '0;
    m_blocks = '0;
    m_errs   = '0;
    m_error  = 1'b0;
    m_idx    = '0;
    m_data   = '0;
  endtask

  task automatic model_word(input logic [31:0] d);
    if (i_check_en && d !== m_exp) begin
      if (!m_error) begin
        m_idx  = m_words;
        m_data = d;
      end
      m_error = 1'b1;
      m_errs  = m_errs + 1;
    end
    m_words = m_words + 1;
    m_exp   = m_exp + 1;
  endtask

  task automatic do_clear(input logic [31:0] seed);
    i_seed  = seed;
    i_clear = 1'b1;
    @(posedge clk); #1;
    i_clear = 1'b0;
    model_reset(seed);
  endtask

  // Offers one block of src[] words, records claim/strobe/release times and
  // feeds each consumed word to the scoreboard. clear_at pulses i_clear on
  // that strobe; drop_en deasserts i_enable right after the claim.
  task automatic run_block(input int size, input bit keep_rdy, input int clear_at, input bit drop_en);
    int guard;
    int idx;
    got_timeout = 1'b0;
    stb_times.delete();
    i_rd_size = 24'(size);
    i_rd_rdy  = 1'b1;
    guard = 0;
    while (o_rd_act !== 1'b1 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (o_rd_act !== 1'b1) begin
      got_timeout = 1'b1;
      i_rd_rdy    = 1'b0;
      return;
    end
    t_act = cyc;
    if (!keep_rdy) i_rd_rdy = 1'b0;
    if (drop_en) i_enable = 1'b0;
    idx   = 0;
    guard = 0;
    while (o_rd_act === 1'b1 && guard < 3000) begin
      i_clear = 1'b0;
      if (o_rd_stb === 1'b1) begin
        stb_times.push_back(cyc);
        i_rd_data = (idx < src.size()) ? src[idx] : 32'hDEAD_BEEF;
        if (idx == clear_at) begin
          i_clear = 1'b1;
          model_reset(i_seed + 32'd1);
        end else begin
          model_word(i_rd_data);
        end
        idx++;
      end else begin
        i_rd_data = $urandom;
      end
      @(posedge clk); #1;
      guard++;
    end
    i_clear = 1'b0;
    if (o_rd_act === 1'b1) begin
      got_timeout = 1'b1;
      return;
    end
    t_fall       = cyc;
    busy_at_fall = o_busy;
    m_blocks     = m_blocks + 1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst    = 1'b1;
    i_seed = 32'h0000_0000;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({o_rd_act, o_rd_stb, o_busy, o_error, o_word_count, o_block_count, o_error_count,
         o_first_err_index, o_first_err_data} !== '0)
      $display("FAIL reset_outputs: got act=%b stb=%b busy=%b %s, want all zero",
               o_rd_act, o_rd_stb, o_busy, dut_str());
    else passes++;
    rst = 1'b0;
    model_reset(i_seed);
    @(posedge clk); #1;
    checks++;
    if ({o_rd_act, o_busy} !== 2'b00)
      $display("FAIL reset_idle: got act=%b busy=%b, want 0 0", o_rd_act, o_busy);
    else passes++;
  endtask

  task automatic test_basic();
    do_clear(32'h0);
    i_throttle = 8'd0;
    src = '{32'd0, 32'd1, 32'd2, 32'd3};
    run_block(4, 1'b0, -1, 1'b0);
    checks++;
    if (got_timeout) $display("FAIL basic_timeout: got no complete block, want one");
    else passes++;
    checks++;
    if (stb_times.size() != 4 || first_bad_stb(0) != -1)
      $display("FAIL basic_stb: got %0d strobes (bad idx %0d), want 4 consecutive", stb_times.size(), first_bad_stb(0));
    else passes++;
    checks++;
    if (t_fall - t_act != 5) $display("FAIL basic_act_len: got %0d, want 5", t_fall - t_act);
    else passes++;
    checks++;
    if (busy_at_fall !== 1'b1) $display("FAIL basic_busy_release: got %b, want 1", busy_at_fall);
    else passes++;
    checks++;
    if (dut_vec() !== model_vec()) $display("FAIL basic_stats: got %s want %s", dut_str(), model_str());
    else passes++;
    @(posedge clk); #1;
    checks++;
    if (o_busy !== 1'b0) $display("FAIL basic_busy_idle: got %b, want 0", o_busy);
    else passes++;
  endtask

  task automatic test_mismatch();
    do_clear(32'h0);
    src = '{32'd0, 32'd1, 32'd7, 32'd3};
    run_block(4, 1'b0, -1, 1'b0);
    checks++;
    if (dut_vec() !== model_vec()) $display("FAIL mismatch_stats: got %s want %s", dut_str(), model_str());
    else passes++;
    checks++;
    if ({o_error_count, o_error, o_first_err_index, o_first_err_data} !== {32'd1, 1'b1, 32'd2, 32'd7})
      $display("FAIL mismatch_capture: got e=%0d err=%b idx=%0d data=%0d, want 1 1 2 7",
               o_error_count, o_error, o_first_err_index, o_first_err_data);
    else passes++;
    src = '{32'd4, 32'd5, 32'd6, 32'd7};
    run_block(4, 1'b0, -1, 1'b0);
    checks++;
    if (got_timeout || dut_vec() !== model_vec())
      $display("FAIL mismatch_followup: got %s timeout=%b want %s", dut_str(), got_timeout, model_str());
    else passes++;
  endtask

  task automatic test_throttle();
    do_clear(32'h100);
    i_throttle = 8'd2;
    src = '{32'h100, 32'h101, 32'h102};
    run_block(3, 1'b0, -1, 1'b0);
    checks++;
    if (got_timeout || stb_times.size() != 3 || first_bad_stb(2) != -1)
      $display("FAIL throttle_stb: got %0d strobes (bad idx %0d), want 3 spaced by 3", stb_times.size(), first_bad_stb(2));
    else passes++;
    checks++;
    if (stb_times.size() == 3 && t_fall != stb_times[2] + 1)
      $display("FAIL throttle_fall: got edge %0d, want %0d", t_fall, stb_times[2] + 1);
    else passes++;
    checks++;
    if (dut_vec() !== model_vec()) $display("FAIL throttle_stats: got %s want %s", dut_str(), model_str());
    else passes++;
    i_throttle = 8'd0;
  endtask

  task automatic test_size_zero();
    do_clear(32'h5);
    src.delete();
    run_block(0, 1'b0, -1, 1'b0);
    checks++;
    if (got_timeout || stb_times.size() != 0 || t_fall != t_act + 1)
      $display("FAIL size0_timing: got strobes=%0d act_len=%0d, want 0 and 1", stb_times.size(), t_fall - t_act);
    else passes++;
    checks++;
    if (dut_vec() !== model_vec()) $display("FAIL size0_stats: got %s want %s", dut_str(), model_str());
    else passes++;
  endtask

  task automatic test_wrap_back_to_back();
    int prev_fall;
    do_clear(32'hFFFF_FFFE);
    src = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0};
    run_block(3, 1'b1, -1, 1'b0);
    prev_fall = t_fall;
    checks++;
    if (got_timeout || t_fall != exp_fall(3, 0))
      $display("FAIL wrap_first_block: got fall=%0d, want %0d", t_fall, exp_fall(3, 0));
    else passes++;
    src = '{32'h1, 32'h2};
    run_block(2, 1'b0, -1, 1'b0);
    checks++;
    if (got_timeout || t_act - prev_fall != 2)
      $display("FAIL b2b_gap: got %0d act-low cycles, want 2", t_act - prev_fall);
    else passes++;
    checks++;
    if (dut_vec() !== model_vec() || o_error_count !== 32'd0)
      $display("FAIL wrap_stats: got %s want %s", dut_str(), model_str());
    else passes++;
  endtask

  task automatic test_clear_on_stb();
    do_clear(32'h50);
    i_seed = 32'h0000_7000;
    src = '{32'h99, 32'h1234, 32'h7001, 32'h7002};
    run_block(4, 1'b0, 1, 1'b0);
    checks++;
    if (got_timeout || t_fall != exp_fall(4, 0))
      $display("FAIL clear_block_timing: got fall=%0d, want %0d", t_fall, exp_fall(4, 0));
    else passes++;
    checks++;
    if (dut_vec() !== model_vec() || o_word_count !== 32'd2)
      $display("FAIL clear_on_stb_stats: got %s want %s", dut_str(), model_str());
    else passes++;
  endtask

  task automatic test_enable_drop();
    bit saw_act;
    do_clear(32'h40);
    src = '{32'h40, 32'h41};
    run_block(2, 1'b1, -1, 1'b1);
    checks++;
    if (got_timeout || t_fall != exp_fall(2, 0))
      $display("FAIL enable_drop_block: got fall=%0d timeout=%b, want %0d", t_fall, got_timeout, exp_fall(2, 0));
    else passes++;
    saw_act = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (o_rd_act === 1'b1) saw_act = 1'b1;
    end
    checks++;
    if (saw_act) $display("FAIL enable_drop_reclaim: got a new claim, want none");
    else passes++;
    i_rd_rdy = 1'b0;
    i_enable = 1'b1;
    checks++;
    if (dut_vec() !== model_vec()) $display("FAIL enable_drop_stats: got %s want %s", dut_str(), model_str());
    else passes++;
  endtask

  task automatic test_reset_mid_block();
    int guard;
    logic [31:0] d;
    do_clear(32'h0000_0A00);
    i_rd_size = 24'd8;
    i_rd_rdy  = 1'b1;
    guard = 0;
    while (o_rd_act !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    if (o_rd_act !== 1'b1) $display("FAIL rst_mid_claim: got act=%b, want 1", o_rd_act);
    else passes++;
    i_rd_rdy = 1'b0;
    d = 32'h0000_0A00;
    repeat (3) begin
      if (o_rd_stb === 1'b1) begin
        i_rd_data = d;
        d = d + 1;
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({o_rd_act, o_rd_stb, o_busy, o_error, o_word_count, o_block_count, o_error_count,
         o_first_err_index, o_first_err_data} !== '0)
      $display("FAIL rst_mid_outputs: got act=%b stb=%b busy=%b %s, want all zero",
               o_rd_act, o_rd_stb, o_busy, dut_str());
    else passes++;
    rst = 1'b0;
    model_reset(i_seed);
    src = '{32'h0000_0A00, 32'h0000_0A01};
    run_block(2, 1'b0, -1, 1'b0);
    checks++;
    if (got_timeout || dut_vec() !== model_vec())
      $display("FAIL rst_mid_reload: got %s timeout=%b want %s", dut_str(), got_timeout, model_str());
    else passes++;
  endtask

  task automatic test_random();
    int size;
    int thr;
    bit keep;
    logic [31:0] d;
    do_clear($urandom);
    for (int b = 0; b < 30; b++) begin
      size       = $urandom_range(0, 6);
      thr        = $urandom_range(0, 3);
      i_throttle = 8'(thr);
      i_check_en = ($urandom_range(0, 3) != 0);
      keep       = (b < 29) ? 1'($urandom_range(0, 1)) : 1'b0;
      src.delete();
      for (int i = 0; i < size; i++) begin
        d = m_exp + 32'(i);
        if ($urandom_range(0, 5) == 0) d = d ^ (32'd1 << $urandom_range(0, 31));
        src.push_back(d);
      end
      run_block(size, keep, -1, 1'b0);
      checks++;
      if (got_timeout || stb_times.size() != size || first_bad_stb(thr) != -1 || t_fall != exp_fall(size, thr))
        $display("FAIL rand_timing[%0d]: got strobes=%0d bad=%0d fall=%0d timeout=%b, want %0d strobes fall=%0d",
                 b, stb_times.size(), first_bad_stb(thr), t_fall, got_timeout, size, exp_fall(size, thr));
      else passes++;
      checks++;
      if (dut_vec() !== model_vec()) $display("FAIL rand_stats[%0d]: got %s want %s", b, dut_str(), model_str());
      else passes++;
    end
    i_rd_rdy   = 1'b0;
    i_check_en = 1'b1;
    i_throttle = 8'd0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    i_enable   = 1'b1;
    i_check_en = 1'b1;
    i_clear    = 1'b0;
    i_seed     = '0;
    i_throttle = '0;
    i_rd_rdy   = 1'b0;
    i_rd_size  = '0;
    i_rd_data  = '0;
    test_reset();
    test_basic();
    test_mismatch();
    test_throttle();
    test_size_zero();
    test_wrap_back_to_back();
    test_clear_on_stb();
    test_enable_drop();
    test_reset_mid_block();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
